// File: rtl/ucsbece154a_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// multicycle core and a debug/loader port; one transaction at a time.
module ucsbece154a_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic [DATA_W-1:0] c_rdata_o,
  output logic              c_done_o,
  output logic              c_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              wr, wr_d;
  logic              grant;
  logic              owner_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] c_rdata_d, d_rdata_d;
  logic              c_done_d, d_done_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    wr_d        = wr;
    grant       = owner_o;
    owner_d     = owner_o;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    c_rdata_d   = c_rdata_o;
    d_rdata_d   = d_rdata_o;
    c_done_d    = 1'b0;
    d_done_d    = 1'b0;

    case (state)
      IDLE: begin
        if (c_req_i || d_req_i) begin
          // Under contention the side that did not own the memory last wins.
          grant       = (c_req_i && d_req_i) ? ~owner_o : d_req_i;
          owner_d     = grant;
          mem_en_d    = 1'b1;
          mem_we_d    = (grant == OWN_DBG) ? d_we_i    : c_we_i;
          mem_addr_d  = (grant == OWN_DBG) ? d_addr_i  : c_addr_i;
          mem_wdata_d = (grant == OWN_DBG) ? d_wdata_i : c_wdata_i;
          wr_d        = mem_we_d;
          cnt_d       = LAT_CNT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          if (owner_o == OWN_DBG) begin
            d_done_d = 1'b1;
            if (!wr) d_rdata_d = mem_rdata_i;
          end else begin
            c_done_d = 1'b1;
            if (!wr) c_rdata_d = mem_rdata_i;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wr          <= 1'b0;
      owner_o     <= OWN_DBG;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      c_rdata_o   <= '0;
      d_rdata_o   <= '0;
      c_done_o    <= 1'b0;
      d_done_o    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wr          <= wr_d;
      owner_o     <= owner_d;
      mem_en_o    <= mem_en_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      c_rdata_o   <= c_rdata_d;
      d_rdata_o   <= d_rdata_d;
      c_done_o    <= c_done_d;
      d_done_o    <= d_done_d;
    end
  end

  assign c_stall_o = c_req_i & ~c_done_o;
  assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_ucsbece154a_mem_arbiter.sv
// Bench for ucsbece154a_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level timing model, on MEM_LAT=1 and MEM_LAT=3.
`timescale 1ns/1ps
module tb_ucsbece154a_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic        c_req [2], c_we [2], d_req [2], d_we [2];
  logic [31:0] c_addr [2], c_wdata [2], d_addr [2], d_wdata [2];
  logic [31:0] c_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2];
  logic        c_done [2], c_stall [2], d_done [2], mem_en [2], mem_we [2];
  logic        busy [2], owner [2];

  logic [31:0] init_mem [logic [32:0]];
  logic [31:0] ref_mem  [logic [32:0]];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_read(input logic [32:0] key);
    if (init_mem.exists(key)) return init_mem[key];
    return {key[15:0], ~key[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [32:0] key);
    if (ref_mem.exists(key)) return ref_mem[key];
    return init_read(key);
  endfunction

  // Instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3; each has its own memory.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] rdata = '0;
    logic [31:0] mem [logic [31:0]];
    int          pend  = 0;
    logic [31:0] paddr = '0;

    ucsbece154a_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(reset),
      .c_req_i(c_req[g]), .c_we_i(c_we[g]), .c_addr_i(c_addr[g]), .c_wdata_i(c_wdata[g]),
      .c_rdata_o(c_rdata[g]), .c_done_o(c_done[g]), .c_stall_o(c_stall[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_rdata_o(d_rdata[g]), .d_done_o(d_done[g]),
      .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(rdata),
      .busy_o(busy[g]), .owner_o(owner[g])
    );

    // Read data is valid only MEM_LAT cycles after the strobe; junk otherwise.
    always @(posedge clk) begin
      if (mem_en[g] === 1'b1) begin
        if (mem_we[g]) mem[mem_addr[g]] = mem_wdata[g];
        else begin
          pend  = (g == 0) ? 1 : 3;
          paddr = mem_addr[g];
        end
      end
      #1;
      if (pend == 1) rdata = mem.exists(paddr) ? mem[paddr] : init_read({(g == 1), paddr});
      else           rdata = $urandom;
      if (pend > 0) pend = pend - 1;
    end
  end

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_en[k], mem_we[k], c_done[k], d_done[k], busy[k], c_stall[k]} !== 6'b0) begin
        bad++;
        $display("FAIL reset_ctrl inst%0d: got %b want 000000", k,
                 {mem_en[k], mem_we[k], c_done[k], d_done[k], busy[k], c_stall[k]});
      end
      total++;
      if (owner[k] !== 1'b1) begin
        bad++; $display("FAIL reset_owner inst%0d: got %b want 1", k, owner[k]);
      end
      total++;
      if ({c_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]} !== 128'b0) begin
        bad++; $display("FAIL reset_data inst%0d: got %h want 0", k,
                        {c_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_core_read();
    init_mem[{1'b0, 32'h40}] = 32'hDEADBEEF;
    do_reset();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h40;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      total++;
      if (mem_en[0] !== (t == 1)) begin
        bad++; $display("FAIL cread_en t=%0d: got %b want %b", t, mem_en[0], (t == 1));
      end
      if (t == 1) begin
        total++;
        if (mem_addr[0] !== 32'h40 || mem_we[0] !== 1'b0) begin
          bad++; $display("FAIL cread_addr: got %h/%b want 00000040/0", mem_addr[0], mem_we[0]);
        end
      end
      total++;
      if (c_done[0] !== (t == 3) || d_done[0] !== 1'b0) begin
        bad++; $display("FAIL cread_done t=%0d: got c=%b d=%b want c=%b d=0", t, c_done[0], d_done[0], (t == 3));
      end
      total++;
      if (c_stall[0] !== (t <= 2)) begin
        bad++; $display("FAIL cread_stall t=%0d: got %b want %b", t, c_stall[0], (t <= 2));
      end
      total++;
      if (busy[0] !== (t >= 1 && t <= 3)) begin
        bad++; $display("FAIL cread_busy t=%0d: got %b want %b", t, busy[0], (t >= 1 && t <= 3));
      end
      if (t == 3) begin
        total++;
        if (c_rdata[0] !== 32'hDEADBEEF) begin
          bad++; $display("FAIL cread_data: got %h want deadbeef", c_rdata[0]);
        end
      end
      @(posedge clk); #1;
      if (t == 3) c_req[0] = 1'b0;
    end
  endtask

  task automatic test_write_then_read();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h80; d_wdata[0] = 32'h12345678;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      total++;
      if (mem_en[0] !== (t == 1 || t == 5)) begin
        bad++; $display("FAIL wr_en t=%0d: got %b want %b", t, mem_en[0], (t == 1 || t == 5));
      end
      if (t == 1) begin
        total++;
        if ({mem_we[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 32'h80, 32'h12345678}) begin
          bad++; $display("FAIL wr_strobe: got %b/%h/%h want 1/00000080/12345678",
                          mem_we[0], mem_addr[0], mem_wdata[0]);
        end
      end
      total++;
      if (d_done[0] !== (t == 3) || c_done[0] !== (t == 7)) begin
        bad++; $display("FAIL wr_done t=%0d: got d=%b c=%b want d=%b c=%b", t, d_done[0], c_done[0], (t == 3), (t == 7));
      end
      if (t == 3) begin
        total++;
        if (d_rdata[0] !== 32'h0 || c_rdata[0] !== 32'hDEADBEEF || owner[0] !== 1'b1) begin
          bad++; $display("FAIL wr_hold: got d=%h c=%h own=%b want 0/deadbeef/1", d_rdata[0], c_rdata[0], owner[0]);
        end
      end
      if (t == 7) begin
        total++;
        if (c_rdata[0] !== 32'h12345678 || d_rdata[0] !== 32'h0 || owner[0] !== 1'b0) begin
          bad++; $display("FAIL rd_after_wr: got c=%h d=%h own=%b want 12345678/0/0", c_rdata[0], d_rdata[0], owner[0]);
        end
      end
      @(posedge clk); #1;
      if (t == 3) begin
        d_req[0] = 1'b0;
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h80;
      end
      if (t == 7) c_req[0] = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      total++;
      if (mem_en[0] !== ((t % 4) == 1)) begin
        bad++; $display("FAIL rr_en t=%0d: got %b want %b", t, mem_en[0], ((t % 4) == 1));
      end
      total++;
      if (c_done[0] !== ((t % 8) == 3) || d_done[0] !== ((t % 8) == 7)) begin
        bad++; $display("FAIL rr_done t=%0d: got c=%b d=%b want c=%b d=%b", t, c_done[0], d_done[0],
                        ((t % 8) == 3), ((t % 8) == 7));
      end
      if ((t % 8) == 3) begin
        total++;
        if (owner[0] !== 1'b0 || c_rdata[0] !== 32'hDEADBEEF) begin
          bad++; $display("FAIL rr_core t=%0d: got own=%b data=%h want 0/deadbeef", t, owner[0], c_rdata[0]);
        end
      end
      if ((t % 8) == 7) begin
        total++;
        if (owner[0] !== 1'b1 || d_rdata[0] !== 32'h12345678) begin
          bad++; $display("FAIL rr_dbg t=%0d: got own=%b data=%h want 1/12345678", t, owner[0], d_rdata[0]);
        end
      end
      @(posedge clk); #1;
      if (t == 15) begin c_req[0] = 1'b0; d_req[0] = 1'b0; end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h40;
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      total++;
      if (mem_en[0] !== (t == 1 || t == 5 || t == 9)) begin
        bad++; $display("FAIL b2b_en t=%0d: got %b want %b", t, mem_en[0], (t == 1 || t == 5 || t == 9));
      end
      total++;
      if (c_done[0] !== (t == 3 || t == 11) || d_done[0] !== (t == 7)) begin
        bad++; $display("FAIL b2b_done t=%0d: got c=%b d=%b want c=%b d=%b", t, c_done[0], d_done[0],
                        (t == 3 || t == 11), (t == 7));
      end
      if (t >= 4 && t <= 10) begin
        total++;
        if (c_stall[0] !== 1'b1) begin
          bad++; $display("FAIL b2b_stall t=%0d: got %b want 1", t, c_stall[0]);
        end
      end
      @(posedge clk); #1;
      if (t == 2) begin d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80; end
      if (t == 7) d_req[0] = 1'b0;
      if (t == 11) c_req[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h40;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 2) begin
        total++;
        if (busy[0] !== 1'b1 || owner[0] !== 1'b0) begin
          bad++; $display("FAIL rmid_pre: got busy=%b own=%b want 1/0", busy[0], owner[0]);
        end
      end
      if (t == 3) begin
        total++;
        if ({busy[0], owner[0], mem_en[0], mem_addr[0], c_rdata[0]} !== {1'b0, 1'b1, 1'b0, 64'b0}) begin
          bad++; $display("FAIL rmid_post: got busy=%b own=%b en=%b addr=%h rd=%h want 0/1/0/0/0",
                          busy[0], owner[0], mem_en[0], mem_addr[0], c_rdata[0]);
        end
      end
      total++;
      if (c_done[0] !== (t == 8)) begin
        bad++; $display("FAIL rmid_done t=%0d: got %b want %b", t, c_done[0], (t == 8));
      end
      if (t == 8) begin
        total++;
        if (c_rdata[0] !== 32'hDEADBEEF) begin
          bad++; $display("FAIL rmid_data: got %h want deadbeef", c_rdata[0]);
        end
      end
      @(posedge clk); #1;
      if (t == 1) reset = 1'b1;
      if (t == 2) begin reset = 1'b0; c_req[0] = 1'b0; end
      if (t == 4) c_req[0] = 1'b1;
      if (t == 8) c_req[0] = 1'b0;
    end
  endtask

  task automatic test_latency3();
    init_mem[{1'b1, 32'h40}] = 32'hCAFEF00D;
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h40;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      total++;
      if (mem_en[1] !== (t == 1)) begin
        bad++; $display("FAIL lat3_en t=%0d: got %b want %b", t, mem_en[1], (t == 1));
      end
      total++;
      if (c_done[1] !== (t == 5) || c_stall[1] !== (t <= 4) || busy[1] !== (t >= 1 && t <= 5)) begin
        bad++; $display("FAIL lat3_ctrl t=%0d: got done=%b stall=%b busy=%b", t, c_done[1], c_stall[1], busy[1]);
      end
      if (t == 5) begin
        total++;
        if (c_rdata[1] !== 32'hCAFEF00D) begin
          bad++; $display("FAIL lat3_data: got %h want cafef00d", c_rdata[1]);
        end
      end
      @(posedge clk); #1;
      if (t == 5) c_req[1] = 1'b0;
    end
  endtask

  // Transaction-level model: a grant happens in the first free cycle with a
  // pending request; strobe one cycle later, done LAT+2 later, free LAT+3 later.
  task automatic test_random(input int k, input int ncyc);
    int          lat = lat_of(k);
    int          free_at = 0, g_t = -1, strobe = -1, done_c = -1, done_d = -1;
    logic        last = 1'b1, g_own = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0, rd_val = '0, exp_cr = '0, exp_dr = '0;
    do_reset();
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (t == done_c && !s_we) exp_cr = rd_val;
      if (t == done_d && !s_we) exp_dr = rd_val;
      total++;
      if (c_done[k] !== (t == done_c) || d_done[k] !== (t == done_d)) begin
        bad++; $display("FAIL rnd%0d_done t=%0d: got c=%b d=%b want c=%b d=%b", k, t,
                        c_done[k], d_done[k], (t == done_c), (t == done_d));
      end
      total++;
      if (c_rdata[k] !== exp_cr || d_rdata[k] !== exp_dr) begin
        bad++; $display("FAIL rnd%0d_rdata t=%0d: got c=%h d=%h want c=%h d=%h", k, t,
                        c_rdata[k], d_rdata[k], exp_cr, exp_dr);
      end
      total++;
      if (mem_en[k] !== (t == strobe) || owner[k] !== last) begin
        bad++; $display("FAIL rnd%0d_en_own t=%0d: got en=%b own=%b want en=%b own=%b", k, t,
                        mem_en[k], owner[k], (t == strobe), last);
      end
      if (t == strobe) begin
        total++;
        if (mem_we[k] !== s_we) begin
          bad++; $display("FAIL rnd%0d_we t=%0d: got %b want %b", k, t, mem_we[k], s_we);
        end
      end
      if (g_t >= 0 && t > g_t) begin
        total++;
        if (mem_addr[k] !== s_addr || mem_wdata[k] !== s_wdata) begin
          bad++; $display("FAIL rnd%0d_bus t=%0d: got %h/%h want %h/%h", k, t,
                          mem_addr[k], mem_wdata[k], s_addr, s_wdata);
        end
      end
      total++;
      if (busy[k] !== (g_t >= 0 && t > g_t && t < free_at) ||
          c_stall[k] !== (c_req[k] && t != done_c)) begin
        bad++; $display("FAIL rnd%0d_busy_stall t=%0d: got %b/%b", k, t, busy[k], c_stall[k]);
      end
      if (t >= free_at && (c_req[k] || d_req[k])) begin
        g_own   = (c_req[k] && d_req[k]) ? ~last : d_req[k];
        s_we    = g_own ? d_we[k]    : c_we[k];
        s_addr  = g_own ? d_addr[k]  : c_addr[k];
        s_wdata = g_own ? d_wdata[k] : c_wdata[k];
        if (s_we) ref_mem[{(k == 1), s_addr}] = s_wdata;
        else      rd_val = ref_read({(k == 1), s_addr});
        g_t     = t;
        strobe  = t + 1;
        free_at = t + lat + 3;
        if (g_own) done_d = t + lat + 2;
        else       done_c = t + lat + 2;
        last    = g_own;
      end
      @(posedge clk); #1;
      if (!c_req[k])       c_req[k] = (($urandom % 3) == 0);
      else if (t == done_c) c_req[k] = 1'($urandom % 2);
      if (!d_req[k])       d_req[k] = (($urandom % 3) == 0);
      else if (t == done_d) d_req[k] = 1'($urandom % 2);
      c_we[k]    = 1'($urandom % 2);
      d_we[k]    = 1'($urandom % 2);
      c_addr[k]  = 32'h100 + 32'(($urandom % 8) * 4);
      d_addr[k]  = 32'h100 + 32'(($urandom % 8) * 4);
      c_wdata[k] = $urandom;
      d_wdata[k] = $urandom;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_core_read();
    test_write_then_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_latency3();
    test_random(0, 400);
    test_random(1, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_mem_arbiter.md
Name: ucsbece154a_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters:
  - the multicycle core's memory interface (instruction fetch, lw, sw);
  - a debug/loader port used for program load and memory inspection.
- Arbitrates between them with round-robin priority, sequences each access through a fixed-latency memory, and returns a one-cycle done pulse with registered read data.
- The core controller holds its current FSM state while its request is pending and done has not yet arrived.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en_o high to mem_rdata_i valid. Must be >= 1.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- c_req_i  input  1  core request; held until c_done_o
- c_we_i  input  1  core write enable
- c_addr_i  input  ADDR_W  core address
- c_wdata_i  input  DATA_W  core write data
- c_rdata_o  output  DATA_W  core read data; valid when c_done_o
- c_done_o  output  1  core transaction complete (1-cycle pulse)
- c_stall_o  output  1  core must hold state
- d_req_i  input  1  debug request; held until d_done_o
- d_we_i  input  1  debug write enable
- d_addr_i  input  ADDR_W  debug address
- d_wdata_i  input  DATA_W  debug write data
- d_rdata_o  output  DATA_W  debug read data
- d_done_o  output  1  debug transaction complete (1-cycle pulse)
- mem_en_o  output  1  memory access strobe (1 cycle)
- mem_we_o  output  1  memory write
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data
- busy_o  output  1  transaction in progress
- owner_o  output  1  current/last grant: 0 = core, 1 = debug

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values:
  - state IDLE;
  - mem_en_o, mem_we_o, c_done_o, d_done_o = 0;
  - c_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o = 0;
  - owner_o = 1 (last owner = debug), so the core wins the first contention.
- All outputs are registered except c_stall_o and busy_o.
- State IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that is not owner_o (round-robin).
  - On a grant:
    - owner_o <= grantee;
    - mem_en_o <= 1;
    - mem_we_o <= grantee's we;
    - mem_addr_o and mem_wdata_o <= grantee's addr and wdata;
    - cnt <= MEM_LAT;
    - next state ACCESS.
- State ACCESS:
  - mem_en_o and mem_we_o drop to 0 after the first cycle.
  - mem_addr_o and mem_wdata_o hold their values.
  - While cnt != 0: cnt decrements each cycle.
  - When cnt == 0:
    - for a read, the owner's rdata_o <= mem_rdata_i;
    - the owner's done_o <= 1;
    - next state RESP.
- State RESP:
  - The owner's done_o is high for exactly this cycle; next state IDLE.
  - Requests are not sampled in RESP. A requester that keeps req high after done is treated as a new request in IDLE.
- Writes:
  - Same timing as reads.
  - The owner's rdata_o keeps its previous value.
- Latency: request first seen in IDLE at cycle T -> mem_en_o high at T+1 -> done at T+MEM_LAT+2.
- Minimum back-to-back spacing is MEM_LAT+3 cycles per transaction.
- c_stall_o = c_req_i & ~c_done_o (combinational).
- busy_o = (state != IDLE).
- Only the owner's done_o and rdata_o change. The non-owner's outputs hold.
- A request dropped mid-transaction is a protocol violation. The arbiter still completes the access and pulses done.
- Requester fields are sampled only at the grant. Later changes are ignored.
- Reset during ACCESS or RESP:
  - return to IDLE and clear all outputs to their reset values;
  - no done pulse is produced;
  - a write already strobed may have reached memory.
- cnt width: $clog2(MEM_LAT+1) bits.
- The next state from an unreachable state encoding is IDLE.

Test Plan:
- Core read only, MEM_LAT=1, mem holds 0xDEADBEEF at 0x40. c_req at cycle 0 -> mem_en_o=1 with addr 0x40 at cycle 1; c_done_o=1 and c_rdata_o=0xDEADBEEF at cycle 3; c_stall_o=1 for cycles 0-2.
- Debug write 0x12345678 to 0x80, then core read of 0x80 -> mem_we_o=1 at grant; the core later reads 0x12345678; d_rdata_o is unchanged by the write.
- Both requests asserted continuously from reset (first request cycle 0) -> grants alternate core, debug, core, debug; owner_o toggles; each done is spaced MEM_LAT+3 cycles apart.
- MEM_LAT=3, core read -> done exactly at T+5; mem_en_o high for only one cycle.
- Reset asserted in the 2nd ACCESS cycle -> next cycle in IDLE with no done pulse and owner_o=1; a fresh core request then completes normally.
- Core holds req high through done -> a second transaction starts from IDLE one cycle after RESP, and debug is granted first if it is also pending.
